// File: rtl/tdp_ram_stream_reader_if.sv
// tdp_ram_stream_reader_if: valid/ready/last word stream; master drives data, valid, last and slave drives ready
interface tdp_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic ready;
  logic last;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/tdp_ram_stream_reader.sv
// tdp_ram_stream_reader: sweeps a wrap-around RAM address range and streams the words through a 2-entry skid FIFO
// Ports: clk/rst_n (sync active-low), start/base_addr/len command, busy/done status,
// ram_en/ram_addr/ram_dout read port (1-cycle latency), m stream master (data, valid, ready, last).
module tdp_ram_stream_reader #(
  parameter int RAM_DEPTH  = 32,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  tdp_ram_stream_reader_if.master m
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [LEN_WIDTH-1:0] issue_left, out_left;
  logic [DATA_WIDTH-1:0] mem [2];
  logic wr_ptr, rd_ptr, inflight, pop;
  logic [1:0] count;
  logic [2:0] occ;
  assign pop = m.valid & m.ready;
  // occupancy the FIFO will have once the outstanding read lands, so a new read never overflows it
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign ram_en = state == S_RUN && issue_left != '0 && occ < 3'd2;
  assign ram_addr = issue_addr;
  assign m.valid = count != '0;
  assign m.data = mem[rd_ptr];
  assign m.last = m.valid && out_left == LEN_WIDTH'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      issue_addr <= '0;
      issue_left <= '0;
      out_left <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      inflight <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      inflight <= ram_en;
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (ram_en) begin
        issue_addr <= issue_addr == ADDR_WIDTH'(RAM_DEPTH - 1) ? '0 : issue_addr + ADDR_WIDTH'(1);
        issue_left <= issue_left - LEN_WIDTH'(1);
      end
      if (inflight) begin
        mem[wr_ptr] <= ram_dout;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        out_left <= out_left - LEN_WIDTH'(1);
      end
      case (state)
        S_IDLE:
          if (start) begin
            issue_addr <= base_addr;
            issue_left <= len;
            out_left <= len;
            state <= len != '0 ? S_RUN : S_DONE;
            busy <= len != '0;
            done <= len == '0;
          end
        S_RUN:
          if (pop && m.last) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdp_ram_stream_reader.sv
// tb_tdp_ram_stream_reader: scoreboard bench for the RAM stream reader at depth 32 plus a depth-24 wrap instance
module tb_tdp_ram_stream_reader;
  logic clk, rst_n;
  logic start, busy, done, ram_en;
  logic [4:0] base_addr, ram_addr;
  logic [5:0] len;
  logic [63:0] ram_dout;
  logic start_b, busy_b, done_b, ram_en_b;
  logic [4:0] base_b, ram_addr_b;
  logic [5:0] len_b;
  logic [63:0] ram_dout_b;
  int checks = 0;
  int failures = 0;
  int hs = 0;
  logic [64:0] exp_q [$];
  logic [4:0] addr_q [$];
  logic [64:0] e;
  bit zero_pend = 0;
  bit prev_stall = 0;
  bit prev_last_hs = 0;
  logic [63:0] prev_data;
  logic prev_last;

  tdp_ram_stream_reader_if #(.DATA_WIDTH(64)) sif();
  tdp_ram_stream_reader_if #(.DATA_WIDTH(64)) sif_b();

  tdp_ram_stream_reader #(.RAM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m(sif.master)
  );

  tdp_ram_stream_reader #(.RAM_DEPTH(24)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b), .len(len_b),
    .busy(busy_b), .done(done_b), .ram_en(ram_en_b), .ram_addr(ram_addr_b), .ram_dout(ram_dout_b),
    .m(sif_b.master)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) ram_dout <= 64'(ram_addr) + 64'd100;
    if (ram_en_b) ram_dout_b <= 64'(ram_addr_b) + 64'd200;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int b, input int n);
    base_addr = 5'(b);
    len = 6'(n);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      addr_q.push_back(5'((b + k) % 32));
      exp_q.push_back({k == n - 1, 64'((b + k) % 32 + 100)});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int i = 0;
    while (!done && i < budget) begin
      if (rnd) sif.ready = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
    chk("busy_at_done", {63'b0, busy}, 64'd0);
    chk("exp_q_left", 64'(exp_q.size()), 64'd0);
    chk("addr_q_left", 64'(addr_q.size()), 64'd0);
    sif.ready = 1'b1;
    tick();
    chk("done_one_cycle", {63'b0, done}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_data", sif.data, prev_data);
        chk("stall_last", {63'b0, sif.last}, {63'b0, prev_last});
      end
      chk("done_timing", {63'b0, done}, {63'b0, prev_last_hs | zero_pend});
      if (ram_en) begin
        chk("issue_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) chk("ram_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
      end
      if (sif.valid && sif.ready) begin
        hs++;
        chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_data", sif.data, e[63:0]);
          chk("m_last", {63'b0, sif.last}, {63'b0, e[64]});
        end
      end
    end
    prev_stall = rst_n && sif.valid && !sif.ready;
    prev_data = sif.data;
    prev_last = sif.last;
    prev_last_hs = rst_n && sif.valid && sif.ready && sif.last;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea [4] = '{22, 23, 0, 1};
    int h0;
    int i;
    rst_n = 0; start = 0; base_addr = 0; len = 0; sif.ready = 1;
    start_b = 0; base_b = 0; len_b = 0; sif_b.ready = 1;
    repeat (2) tick();
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_ram_en", {63'b0, ram_en}, 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_valid", {63'b0, sif.valid}, 64'd0);
    chk("rst_last", {63'b0, sif.last}, 64'd0);
    chk("rst_data", sif.data, 64'd0);
    rst_n = 1;
    tick();

    base_b = 5'd22; len_b = 6'd4; start_b = 1;
    tick();
    start_b = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        chk("b_ram_en", {63'b0, ram_en_b}, 64'd1);
        chk("b_ram_addr", 64'(ram_addr_b), 64'(ea[k]));
      end else chk("b_ram_en_off", {63'b0, ram_en_b}, 64'd0);
      chk("b_valid", {63'b0, sif_b.valid}, 64'(k >= 2 && k < 6));
      if (k >= 2 && k < 6) begin
        chk("b_data", sif_b.data, 64'(ea[k - 2] + 200));
        chk("b_last", {63'b0, sif_b.last}, 64'(k == 5));
      end
      chk("b_done", {63'b0, done_b}, 64'(k == 6));
      tick();
    end
    chk("b_done_pulse", {63'b0, done_b}, 64'd0);

    go(3, 4);
    chk("basic_busy", {63'b0, busy}, 64'd1);
    chk("basic_en0", {63'b0, ram_en}, 64'd1);
    chk("basic_addr0", 64'(ram_addr), 64'd3);
    chk("basic_valid0", {63'b0, sif.valid}, 64'd0);
    tick();
    chk("basic_en1", {63'b0, ram_en}, 64'd1);
    chk("basic_valid1", {63'b0, sif.valid}, 64'd0);
    tick();
    chk("basic_valid2", {63'b0, sif.valid}, 64'd1);
    chk("basic_data2", sif.data, 64'd103);
    wait_done(50, 0);

    go(30, 4);
    wait_done(50, 0);

    go(0, 0);
    zero_pend = 1;
    chk("zero_done", {63'b0, done}, 64'd1);
    chk("zero_busy", {63'b0, busy}, 64'd0);
    chk("zero_en", {63'b0, ram_en}, 64'd0);
    chk("zero_valid", {63'b0, sif.valid}, 64'd0);
    tick();
    zero_pend = 0;
    chk("zero_done_end", {63'b0, done}, 64'd0);
    chk("zero_en_end", {63'b0, ram_en}, 64'd0);

    go(12, 8);
    tick();
    tick();
    sif.ready = 0;
    repeat (7) tick();
    chk("bp_en_off", {63'b0, ram_en}, 64'd0);
    chk("bp_valid", {63'b0, sif.valid}, 64'd1);
    chk("bp_head", sif.data, exp_q[0][63:0]);
    wait_done(300, 1);

    go(5, 32);
    repeat (5) tick();
    base_addr = 0; len = 6'd3; start = 1;
    tick();
    start = 0;
    chk("run_start_ignored_busy", {63'b0, busy}, 64'd1);
    wait_done(100, 0);
    go(28, 6);
    wait_done(50, 0);

    go(0, 10);
    i = 0;
    while (hs < 4 && i < 100) begin
      tick();
      i++;
    end
    chk("mid_hs_reached", 64'(hs >= 4), 64'd1);
    rst_n = 0;
    tick();
    exp_q.delete();
    addr_q.delete();
    chk("mid_busy", {63'b0, busy}, 64'd0);
    chk("mid_done", {63'b0, done}, 64'd0);
    chk("mid_ram_en", {63'b0, ram_en}, 64'd0);
    chk("mid_ram_addr", 64'(ram_addr), 64'd0);
    chk("mid_valid", {63'b0, sif.valid}, 64'd0);
    chk("mid_last", {63'b0, sif.last}, 64'd0);
    chk("mid_data", sif.data, 64'd0);
    rst_n = 1;
    tick();
    chk("mid_no_done", {63'b0, done}, 64'd0);
    h0 = hs;
    go(7, 2);
    wait_done(50, 0);
    chk("post_reset_words", 64'(hs - h0), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
